// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit: shift-add multiply and restoring divide on magnitudes, HI/LO result.
// Optional feature: define DIV_ZERO_TRAP_EN for an immediate div_zero completion on DIV by zero.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Unsigned magnitude; the most negative input maps to 2^(WIDTH-1), which fits WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) mag = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    else            mag = v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    neg_w = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_r, state_s;
  logic               busy_r, done_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               op_r, neg_r, sa_r, dz_r;
  logic [WIDTH-1:0]   a_r, opnd_r;
  logic [2*WIDTH-1:0] acc_r, acc_step_s, prod_s;
  logic [CW-1:0]      cnt_r;
  logic               accept_s, trap_s;
  logic [WIDTH:0]     upper_s, shifted_s;
  logic [WIDTH-1:0]   diff_s, quo_s, rem_s;

  assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
`ifdef DIV_ZERO_TRAP_EN
  logic div_zero_r;
  assign trap_s   = accept_s && op && (b == {WIDTH{1'b0}});
  assign div_zero = div_zero_r;
`else
  assign trap_s   = 1'b0;
`endif

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (trap_s)        state_s = DONE;
        else if (accept_s) state_s = RUN;
        else               state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == CW'(1)) state_s = FIX;
        else                 state_s = RUN;
      end
      FIX:     state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // One iteration: shift-add for MULT, restore-or-subtract for DIV
  always_comb begin
    upper_s    = {(WIDTH+1){1'b0}};
    shifted_s  = {(WIDTH+1){1'b0}};
    diff_s     = {WIDTH{1'b0}};
    acc_step_s = acc_r;
    if (op_r == 1'b0) begin
      upper_s    = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                 + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
      acc_step_s = {upper_s, acc_r[WIDTH-1:1]};
    end else begin
      // Remainder lives in the upper half and always stays below the divisor.
      shifted_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      diff_s    = shifted_s[WIDTH-1:0] - opnd_r;
      if (shifted_s < {1'b0, opnd_r}) acc_step_s = {shifted_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      else                            acc_step_s = {diff_s, acc_r[WIDTH-2:0], 1'b1};
    end
  end

  // Sign fix-up of the magnitude result
  always_comb begin
    prod_s = acc_r;
    quo_s  = acc_r[WIDTH-1:0];
    rem_s  = acc_r[2*WIDTH-1:WIDTH];
    if (neg_r) begin
      prod_s = (~acc_r) + {{(2*WIDTH-1){1'b0}}, 1'b1};
      quo_s  = neg_w(acc_r[WIDTH-1:0]);
    end else begin
      prod_s = acc_r;
      quo_s  = acc_r[WIDTH-1:0];
    end
    if (sa_r) rem_s = neg_w(acc_r[2*WIDTH-1:WIDTH]);
    else      rem_s = acc_r[2*WIDTH-1:WIDTH];
  end

  // State and status flags
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN) || (state_s == FIX);
      done_r  <= (state_s == DONE);
    end
  end

`ifdef DIV_ZERO_TRAP_EN
  // Divide-by-zero completion flag, high only in the trapped DONE cycle
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) div_zero_r <= 1'b0;
    else          div_zero_r <= trap_s;
  end
`endif

  // Operand capture and iteration datapath
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      op_r   <= 1'b0;
      neg_r  <= 1'b0;
      sa_r   <= 1'b0;
      dz_r   <= 1'b0;
      a_r    <= {WIDTH{1'b0}};
      opnd_r <= {WIDTH{1'b0}};
      acc_r  <= {(2*WIDTH){1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else if (accept_s && (state_s == RUN)) begin
      op_r   <= op;
      neg_r  <= a[WIDTH-1] ^ b[WIDTH-1];
      sa_r   <= a[WIDTH-1];
      dz_r   <= op && (b == {WIDTH{1'b0}});
      a_r    <= a;
      opnd_r <= op ? mag(b) : mag(a);
      acc_r  <= {{WIDTH{1'b0}}, (op ? mag(a) : mag(b))};
      cnt_r  <= CW'(WIDTH);
    end else if (state_r == RUN) begin
      acc_r  <= acc_step_s;
      cnt_r  <= cnt_r - CW'(1);
    end else begin
      acc_r  <= acc_r;
      cnt_r  <= cnt_r;
    end
  end

  // HI/LO are written only on the FIX edge
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (state_r == FIX) begin
      if (op_r == 1'b0) begin
        hi_r <= prod_s[2*WIDTH-1:WIDTH];
        lo_r <= prod_s[WIDTH-1:0];
      end else if (dz_r) begin
        hi_r <= a_r;
        lo_r <= {WIDTH{1'b1}};
      end else begin
        hi_r <= rem_s;
        lo_r <= quo_s;
      end
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, random model vectors and multi-cycle corner sequences.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset_l = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef DIV_ZERO_TRAP_EN
  logic        div_zero;
`endif

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset_l(reset_l), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef DIV_ZERO_TRAP_EN
    , .div_zero(div_zero)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: drives start for one edge and records the expected result.
  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Waits for done; checks latency, mid-run HI/LO stability and the popped result.
  task automatic await_done(input string name, input int exp_lat, input int repulse_at, input logic exp_dz);
    int   cycles;
    exp_t e;
    cycles = 1;
    while (!done && cycles < 80) begin
      if (cycles == 20) check({name, "_stable"}, {hi, lo}, {last_hi, last_lo});
      if (cycles == repulse_at) begin
        start = 1'b1; a = 32'd9; b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      cycles++;
    end
    start = 1'b0;
    check({name, "_latency"}, 64'(cycles), 64'(exp_lat));
    check({name, "_busy"}, {63'd0, busy}, 64'd0);
`ifdef DIV_ZERO_TRAP_EN
    check({name, "_divzero"}, {63'd0, div_zero}, {63'd0, exp_dz});
`else
    check({name, "_dzflag"}, {63'd0, exp_dz}, {63'd0, 1'b0} | {63'd0, exp_dz & done & 1'b0});
`endif
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_hilo"}, {hi, lo}, {e.hi, e.lo});
      last_hi = e.hi;
      last_lo = e.lo;
    end else begin
      check({name, "_scoreboard_empty"}, 64'd1, 64'd0);
    end
  endtask

  initial begin
    vec_t tbl[7];
    logic [31:0] x, y, eh, el;
    logic        o;
    longint      p;
    int          q, r;
    int          seen;

    tbl[0] = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[1] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[2] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14};
    tbl[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    tbl[5] = '{1'b1, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2};
    tbl[6] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};

    #2;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clock);
    reset_l = 1'b1;
    @(negedge clock);

    // Table vectors; each one after the first starts in the previous DONE cycle.
    for (int i = 0; i < 7; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);
      await_done($sformatf("vec%0d", i), 34, 0, 1'b0);
    end

    // Random vectors against a behavioural model, with an idle gap before each.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      o = 1'($urandom_range(0, 1));
      x = $urandom;
      y = $urandom;
      if (y == 32'd0) y = 32'd3;
      if (x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd5;
      if (o == 1'b0) begin
        p  = longint'($signed(x)) * longint'($signed(y));
        eh = p[63:32];
        el = p[31:0];
      end else begin
        q  = $signed(x) / $signed(y);
        r  = $signed(x) % $signed(y);
        eh = r;
        el = q;
      end
      issue(o, x, y, eh, el);
      await_done($sformatf("rnd%0d", i), 34, 0, 1'b0);
    end

    // Start re-pulsed with new operands mid-run must be ignored.
    @(negedge clock);
    issue(1'b0, 32'd3, 32'd4, 32'd0, 32'd12);
    await_done("repulse", 34, 9, 1'b0);

    // Divide by zero.
    @(negedge clock);
`ifdef DIV_ZERO_TRAP_EN
    issue(1'b1, 32'd5, 32'd0, last_hi, last_lo);
    await_done("divzero", 1, 0, 1'b1);
    @(negedge clock);
    check("divzero_clear", {63'd0, div_zero}, 64'd0);
`else
    issue(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    await_done("divzero", 34, 0, 1'b0);
`endif

    // Reset in the middle of a DIV aborts it with no done pulse.
    @(negedge clock);
    issue(1'b1, 32'd1000, 32'd3, 32'd1, 32'd333);
    for (int c = 1; c < 19; c++) @(negedge clock);
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    reset_l = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    void'(sb.pop_front());
    @(negedge clock);
    reset_l = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    check("abort_hilo_hold", {hi, lo}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
